// File: rtl/openadc_axil_regs.sv
// AXI4-Lite register file for the openadc control port, NUM_REGS x 32-bit.
// Define OPENADC_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module openadc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS = 4,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] REG_RESET = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]          reg_q_o,
  output logic [NUM_REGS-1:0]             reg_wr_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;
  localparam int SW = DW / 8;
  localparam logic [1:0] OKAY = 2'b00;
`ifdef OPENADC_AXIL_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic          aw_full_q, aw_full_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_q, wr_d;

  logic          awready, wready, arready;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] c_idx, r_idx;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;
  logic          c_hit, r_hit;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READYs are forced low while reset is held, so they rise on release
  assign awready = !ARESET && !aw_full_q && !bvalid_q;
  assign wready  = !ARESET && !w_full_q && !bvalid_q;
  assign arready = !ARESET && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID && wready;
  assign ar_hs = S_AXI_ARVALID && arready;

  assign c_idx  = aw_hs ? S_AXI_AWADDR[AW-1:2] : aw_idx_q;
  assign c_data = w_hs ? S_AXI_WDATA : w_data_q;
  assign c_strb = w_hs ? S_AXI_WSTRB : w_strb_q;
  assign commit = (aw_hs || aw_full_q) && (w_hs || w_full_q);
  assign c_hit  = {1'b0, c_idx} < (IW+1)'(NUM_REGS);

  assign r_idx = S_AXI_ARADDR[AW-1:2];
  assign r_hit = {1'b0, r_idx} < (IW+1)'(NUM_REGS);

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_d      = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[AW-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = c_hit ? OKAY : ERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (c_hit && c_idx == IW'(i)) begin
          wr_d[i] = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (c_strb[b]) regs_d[i][8*b +: 8] = c_data[8*b +: 8];
          end
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  // read samples regs_q, so a same-edge write is not visible
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = r_hit ? OKAY : ERR;
      rdata_d  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_hit && r_idx == IW'(i)) rdata_d = regs_q[i];
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      wr_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      wr_q      <= wr_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_o      = wr_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_q_o[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_openadc_axil_regs.sv
// Randomised bench for openadc_axil_regs against a register-array model.
// Honours OPENADC_AXIL_SLVERR_EN for the expected out-of-range response.
module tb_openadc_axil_regs;

`ifdef OPENADC_AXIL_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic        ACLK = 0;
  logic        ARESET;
  logic [4:0]  AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [127:0] reg_q;
  logic [3:0]  reg_wr;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] model [4];

  always #5 ACLK = ~ACLK;

  openadc_axil_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT),
    .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB),
    .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT),
    .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .reg_q_o(reg_q), .reg_wr_o(reg_wr)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] packm();
    logic [127:0] p;
    for (int i = 0; i < 4; i++) p[32*i +: 32] = model[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly,
                          input int w_dly, input int b_dly);
    int cyc, idx;
    bit awd, wd, awgo, wgo;
    logic [1:0] bexp;
    logic [3:0] wexp;
    idx  = int'(a[4:2]);
    bexp = (idx < 4) ? 2'b00 : ERR_RESP;
    wexp = (idx < 4) ? 4'(1 << idx) : 4'b0;
    cyc = 0; awd = 0; wd = 0;
    while (!(awd && wd) && cyc < 40) begin
      AWADDR  = a;
      WDATA   = d;
      WSTRB   = s;
      AWVALID = !awd && cyc >= aw_dly;
      WVALID  = !wd && cyc >= w_dly;
      awgo = AWVALID && AWREADY;
      wgo  = WVALID && WREADY;
      tick();
      awd |= awgo;
      wd  |= wgo;
      cyc++;
      if (!(awd && wd)) begin
        check("bvalid_early", BVALID, 0);
        check("wr_pulse_early", reg_wr, 0);
        if (awd) check("awready_held", AWREADY, 0);
        if (wd) check("wready_held", WREADY, 0);
      end
    end
    AWVALID = 0;
    WVALID  = 0;
    if (!(awd && wd)) check("wr_timeout", 1, 0);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
    check("bvalid", BVALID, 1);
    check("bresp", BRESP, bexp);
    check("wr_pulse", reg_wr, wexp);
    check("regs_after_wr", reg_q, packm());
    for (int k = 0; k < b_dly; k++) begin
      tick();
      check("bvalid_hold", BVALID, 1);
      check("bresp_hold", BRESP, bexp);
      check("aw_blocked", {AWREADY, WREADY}, 0);
      check("wr_pulse_len", reg_wr, 0);
    end
    BREADY = 1;
    tick();
    BREADY = 0;
    check("bvalid_clr", BVALID, 0);
    check("ready_back", {AWREADY, WREADY}, 2'b11);
  endtask

  task automatic do_read(input logic [4:0] a, input int ar_dly,
                         input int r_dly);
    int cyc, idx;
    bit ard, argo;
    logic [31:0] dexp;
    logic [1:0] rexp;
    idx  = int'(a[4:2]);
    dexp = (idx < 4) ? model[idx] : 32'h0;
    rexp = (idx < 4) ? 2'b00 : ERR_RESP;
    cyc = 0; ard = 0;
    while (!ard && cyc < 40) begin
      ARADDR  = a;
      ARVALID = cyc >= ar_dly;
      argo = ARVALID && ARREADY;
      tick();
      ard |= argo;
      cyc++;
      if (!ard) check("rvalid_early", RVALID, 0);
    end
    ARVALID = 0;
    if (!ard) check("rd_timeout", 1, 0);
    check("rvalid", RVALID, 1);
    check("rdata", RDATA, dexp);
    check("rresp", RRESP, rexp);
    for (int k = 0; k < r_dly; k++) begin
      tick();
      check("rhold", {RVALID, RDATA, RRESP}, {1'b1, dexp, rexp});
      check("ar_blocked", ARREADY, 0);
    end
    RREADY = 1;
    tick();
    RREADY = 0;
    check("rvalid_clr", RVALID, 0);
    check("arready_back", ARREADY, 1);
  endtask

  initial begin
    logic [31:0] old, nd;
    ARESET = 1;
    AWADDR = 0; AWPROT = 0; AWVALID = 0;
    WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 4; i++) model[i] = 0;
    repeat (3) tick();
    check("rst_ready", {AWREADY, WREADY, ARREADY}, 0);
    check("rst_valid", {BVALID, RVALID}, 0);
    check("rst_resp", {BRESP, RRESP, RDATA}, 0);
    check("rst_regs", reg_q, packm());
    check("rst_wr", reg_wr, 0);
    ARESET = 0;
    #1;
    check("ready_on_release", {AWREADY, WREADY, ARREADY}, 3'b111);
    tick();

    for (int i = 0; i < 4; i++)
      do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(5'(4 * i), 0, 0);

    do_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(5'h05, 32'h11223344, 4'b0101, 0, 0, 1);
    check("strb_merge", reg_q[63:32], 32'hAA22CC44);
    do_read(5'h04, 1, 0);

    do_write(5'h08, 32'hCAFE0001, 4'hF, 0, 3, 0);
    do_write(5'h0C, 32'hBEEF0002, 4'hF, 2, 0, 0);
    do_write(5'h00, 32'h12345678, 4'hF, 0, 0, 5);
    do_write(5'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    do_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(5'h10, 0, 2);
    do_read(5'h1F, 0, 0);

    repeat (120) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // read and write commit to reg 2 on one edge: read sees the old value
    old = model[2];
    nd  = $urandom;
    AWADDR = 5'h08; WDATA = nd; WSTRB = 4'hF; ARADDR = 5'h08;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    model[2] = nd;
    check("same_edge_rd", {RVALID, RDATA}, {1'b1, old});
    check("same_edge_wr", {BVALID, reg_wr}, {1'b1, 4'b0100});
    check("same_edge_regs", reg_q, packm());
    BREADY = 1; RREADY = 1;
    tick();
    BREADY = 0; RREADY = 0;
    check("same_edge_clr", {BVALID, RVALID}, 0);

    AWADDR = 5'h04; WDATA = 32'h55; WSTRB = 4'hF; ARADDR = 5'h00;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    tick();
    check("pend_before_rst", {BVALID, RVALID}, 2'b11);
    ARESET = 1;
    tick();
    for (int i = 0; i < 4; i++) model[i] = 0;
    check("mid_rst_valid", {BVALID, RVALID}, 0);
    check("mid_rst_ready", {AWREADY, WREADY, ARREADY}, 0);
    check("mid_rst_regs", reg_q, packm());
    ARESET = 0;
    #1;
    check("mid_rst_release", {AWREADY, WREADY, ARREADY}, 3'b111);
    tick();
    do_read(5'h04, 0, 0);
    do_write(5'h0C, 32'h0BADF00D, 4'b1000, 1, 0, 0);
    do_read(5'h0C, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
